mgt_01_div_unit: RTL

MGT_01_DIV_UNIT -- requirements
Module: MGT_01_div_unit

---
 rtl/mgt_01_div_unit_pkg.sv | 26 ++
 rtl/mgt_01_div_unit_step.sv | 29 ++
 rtl/mgt_01_div_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mgt_01_div_unit_pkg.sv
// Shared types and constants for the MGT_01 divide unit.
//   div_ops_e   : divide operation select (quotient/remainder, signed/unsigned)
//   mul_ops_e   : companion multiply operation select
//   div_state_e : divider FSM states
//   data_u      : default-width operand/result word
package mgt_01_div_unit_pkg;

  localparam int unsigned XlenDef  = 32;
  localparam int unsigned DivSteps = XlenDef;

  typedef logic [XlenDef-1:0] data_u;

  typedef enum logic [1:0] {DIV_, DIVU_, REM_, REMU_} div_ops_e;
  typedef enum logic [1:0] {MUL_, MULH_, MULHSU_, MULHU_} mul_ops_e;

  typedef enum logic [1:0] {StIdle, StDivide, StFix, StDone} div_state_e;

  function automatic logic is_signed_op(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic is_rem_op(input div_ops_e op);
    return (op == REM_) || (op == REMU_);
  endfunction

endpackage

// File: rtl/mgt_01_div_unit_step.sv
// One combinational restoring radix-2 division step.
//   rem, quo : current partial remainder and dividend/quotient shift register
//   dvs      : divisor magnitude
//   rem_nxt  : partial remainder after the step
//   quo_nxt  : shift register after the step, new quotient bit in the LSB
module mgt_01_div_unit_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] rem_ext;
  logic [XLEN:0] diff;
  logic          q_bit;

  always_comb begin
    // Extra MSB: 2*rem+1 can exceed XLEN bits, and then it always exceeds dvs.
    rem_ext = {rem, quo[XLEN-1]};
    diff    = rem_ext - {1'b0, dvs};
    q_bit   = ~diff[XLEN];
    rem_nxt = q_bit ? diff[XLEN-1:0] : rem_ext[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], q_bit};
  end

endmodule

// File: rtl/mgt_01_div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU).
//   clk_i, rst_n_i : clock, async active-low reset
//   clk_en_i       : stall, low freezes all state
//   flush_i        : abort the operation in flight
//   valid_i, ops_i, dividend_i, divisor_i : start request and operands
//   ready_o        : idle, can accept a start
//   valid_o        : one-cycle result strobe
//   result_o       : quotient or remainder, held until the next result
module mgt_01_div_unit
  import mgt_01_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = XlenDef
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  div_ops_e        ops_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntWidth = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e            state_q, state_d;
  div_ops_e              op_q, op_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       quo_q, quo_d;
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic                  sgn_in;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic [XLEN-1:0]       fix_quo, fix_rem;
  logic [XLEN-1:0]       step_rem, step_quo;

  mgt_01_div_unit_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  always_comb begin
    sgn_in  = is_signed_op(ops_i);
    mag_a   = (sgn_in && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    mag_b   = (sgn_in && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    fix_quo = neg_quo_q ? -quo_q : quo_q;
    fix_rem = neg_rem_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (clk_en_i) begin
      if (flush_i) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (valid_i) begin
              op_d = ops_i;
              if (divisor_i == '0) begin
                // Divide by zero: quotient all-ones, remainder = dividend.
                result_d = is_rem_op(ops_i) ? dividend_i : '1;
                state_d  = StDone;
              end else if (sgn_in && dividend_i == MinVal && divisor_i == '1) begin
                // Signed overflow: quotient saturates to MinVal, remainder 0.
                result_d = is_rem_op(ops_i) ? '0 : MinVal;
                state_d  = StDone;
              end else begin
                quo_d     = mag_a;
                dvs_d     = mag_b;
                rem_d     = '0;
                cnt_d     = CntWidth'(XLEN - 1);
                neg_quo_d = sgn_in && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                neg_rem_d = sgn_in && dividend_i[XLEN-1];
                state_d   = StDivide;
              end
            end
          end
          StDivide: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_d = StFix;
            end
          end
          StFix: begin
            result_d = is_rem_op(op_q) ? fix_rem : fix_quo;
            state_d  = StDone;
          end
          StDone: begin
            state_d = StIdle;
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      op_q      <= DIV_;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  // A flush landing on the DONE cycle cancels the strobe.
  assign valid_o  = (state_q == StDone) && !(flush_i && clk_en_i);
  assign result_o = result_q;

endmodule
